// File: rtl/strv32i_pkg.sv
// -----------------------------------------------------------------------------
// strv32i_pkg
// Shared definitions for the STRV32I front end:
//   - pc_src_e      : redirect source encodings. The control unit drives these
//                     and fetch_unit decodes them.
//   - fetch_state_e : fetch FSM states.
//   - NOP_INSTR     : canonical bubble (addi x0,x0,0).
//   - redirect_target(): the redirect mux, with the result forced word aligned.
// -----------------------------------------------------------------------------
package strv32i_pkg;

  typedef enum logic [1:0] {
    PC_SRC_BOOT   = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_TRAP   = 2'b10,
    PC_SRC_SEQ    = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_DRAIN = 2'b11
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Select the redirect target and clear bits [1:0] so that imem always
  // sees a word-aligned address, whatever the source supplied.
  function automatic logic [31:0] redirect_target(
    input logic [1:0]  src,
    input logic [31:0] boot_addr,
    input logic [31:0] branch_target,
    input logic [31:0] trap_target,
    input logic [31:0] seq_target
  );
    logic [31:0] t;
    case (src)
      PC_SRC_BOOT:   t = boot_addr;
      PC_SRC_BRANCH: t = branch_target;
      PC_SRC_TRAP:   t = trap_target;
      default:       t = seq_target;
    endcase
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory req/ack bus.
//   imem_req_out   : fetch request (fetch -> memory)
//   imem_addr_out  : word-aligned fetch address (fetch -> memory)
//   imem_ack_in    : response strobe; data valid in the same cycle (memory -> fetch)
//   imem_rdata_in  : instruction word (memory -> fetch)
// master = fetch unit, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_unit_if;

  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_rdata_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_ack_in,
    input  imem_rdata_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_ack_in,
    output imem_rdata_in
  );

endinterface

// File: rtl/fetch_skid_reg.sv
// -----------------------------------------------------------------------------
// fetch_skid_reg
// Two-entry IF/ID holding register: an output slot seen by decode and a
// one-entry skid that catches a response arriving while decode is stalled.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   clear_in         : invalidate both entries at the next edge (flush)
//   stall_in         : decode cannot accept the output slot this cycle
//   push_in          : a fetched word is delivered this cycle
//   push_instr_in    : fetched instruction word
//   push_pc_in       : PC of the fetched word
//   instr_out        : output slot instruction, NOP_INSTR when empty
//   pc_out           : PC of the output slot
//   valid_out        : output slot holds a valid instruction
// -----------------------------------------------------------------------------
module fetch_skid_reg
  import strv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        clear_in,
  input  logic        stall_in,
  input  logic        push_in,
  input  logic [31:0] push_instr_in,
  input  logic [31:0] push_pc_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q,    out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q,    skid_pc_d;
  logic        consume;

  assign consume = out_valid_q && !stall_in;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (clear_in) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // The skid is only occupied while the output slot is full, and no new
      // request is issued meanwhile, so the only event is the slot draining.
      if (!stall_in) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end
    end else if (push_in) begin
      if (!out_valid_q || consume) begin
        out_valid_d = 1'b1;
        out_instr_d = push_instr_in;
        out_pc_d    = push_pc_in;
      end else begin
        skid_valid_d = 1'b1;
        skid_instr_d = push_instr_in;
        skid_pc_d    = push_pc_in;
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign valid_out = out_valid_q;
  assign instr_out = out_valid_q ? out_instr_q : NOP_INSTR;
  assign pc_out    = out_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// STRV32I instruction-fetch front end. Owns the PC, runs the req/ack
// handshake to instruction memory and feeds decode through fetch_skid_reg.
//   clk_in, rst_n_in   : clock, asynchronous active-low reset
//   flush_in           : redirect request from the control unit
//   pc_src_in          : redirect source (pc_src_e), only meaningful with flush_in
//   branch_target_in   : branch/jump target
//   trap_target_in     : trap vector
//   stall_in           : decode cannot accept this cycle
//   imem               : instruction-memory bus (master side)
//   instr_out          : instruction to decode (NOP_INSTR when empty)
//   instr_pc_out       : PC of instr_out
//   instr_valid_out    : instr_out is valid
//   pc_out             : current fetch PC
// -----------------------------------------------------------------------------
module fetch_unit
  import strv32i_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         flush_in,
  input  logic [1:0]   pc_src_in,
  input  logic [31:0]  branch_target_in,
  input  logic [31:0]  trap_target_in,
  input  logic         stall_in,
  fetch_unit_if.master imem,
  output logic [31:0]  instr_out,
  output logic [31:0]  instr_pc_out,
  output logic         instr_valid_out,
  output logic [31:0]  pc_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_q, redirect_d;
  logic [31:0]  target;
  logic         req;
  logic         push;
  logic         clear;

  assign target = redirect_target(pc_src_in, BOOT_ADDR, branch_target_in,
                                  trap_target_in, pc_q + 32'd4);

  // Nothing is held in BOOT, so a flush there only steers the PC.
  assign clear = flush_in && (state_q != ST_BOOT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    req        = 1'b0;
    push       = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if (flush_in) begin
          pc_d    = target;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        req = 1'b1;
        if (imem.imem_ack_in) begin
          if (flush_in) begin
            // Response belongs to the wrong path: drop it and redirect now.
            pc_d = target;
          end else begin
            pc_d = pc_q + 32'd4;
            push = 1'b1;
            // Slot full and not draining: the word lands in the skid.
            if (instr_valid_out && stall_in) begin
              state_d = ST_HOLD;
            end
          end
        end else if (flush_in) begin
          // The request must complete before the PC can move; remember
          // where to go once its (discarded) response arrives.
          redirect_d = target;
          state_d    = ST_DRAIN;
        end
      end

      ST_HOLD: begin
        if (flush_in) begin
          pc_d    = target;
          state_d = ST_FETCH;
        end else if (!stall_in) begin
          state_d = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        req = 1'b1;
        if (flush_in) begin
          redirect_d = target;
        end
        if (imem.imem_ack_in) begin
          // A flush in the ack cycle is the most recent one and wins.
          pc_d    = flush_in ? target : redirect_q;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_BOOT;
      pc_q       <= BOOT_ADDR;
      redirect_q <= BOOT_ADDR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  fetch_skid_reg #(
    .RESET_PC (BOOT_ADDR)
  ) u_skid (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .clear_in      (clear),
    .stall_in      (stall_in),
    .push_in       (push),
    .push_instr_in (imem.imem_rdata_in),
    .push_pc_in    (pc_q),
    .instr_out     (instr_out),
    .pc_out        (instr_pc_out),
    .valid_out     (instr_valid_out)
  );

  // The address is the PC register itself, so it cannot change while a
  // request is outstanding (PC only moves on ack or outside FETCH/DRAIN).
  assign imem.imem_req_out  = req;
  assign imem.imem_addr_out = pc_q;
  assign pc_out             = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import strv32i_pkg::*;

  localparam logic [31:0] DATA_OFS = 32'h1000_0000;
  localparam int NVEC = 23;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  pc_src;
  logic [31:0] br_tgt;
  logic [31:0] trap_tgt;
  logic        stall;
  logic        ack_en;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  fetch_unit_if bus ();

  // Zero-wait-state memory: ack in the request cycle when enabled; each
  // word is its own address plus a fixed offset.
  assign bus.imem_ack_in   = bus.imem_req_out & ack_en;
  assign bus.imem_rdata_in = bus.imem_addr_out + DATA_OFS;

  fetch_unit #(.BOOT_ADDR(32'h0000_0000)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .flush_in         (flush),
    .pc_src_in        (pc_src),
    .branch_target_in (br_tgt),
    .trap_target_in   (trap_tgt),
    .stall_in         (stall),
    .imem             (bus),
    .instr_out        (instr),
    .instr_pc_out     (instr_pc),
    .instr_valid_out  (instr_valid),
    .pc_out           (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [1:0]  src;
    logic [31:0] br;
    logic [31:0] trap;
    logic        stall;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs [0:NVEC-1];

  function automatic vec_t mk(input logic f, input logic [1:0] s,
                              input logic [31:0] br, input logic [31:0] tr,
                              input logic st, input logic ak, input logic er,
                              input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep);
    vec_t v;
    v.flush = f;  v.src = s;    v.br = br;     v.trap = tr;
    v.stall = st; v.ack = ak;   v.e_req = er;  v.e_addr = ea;
    v.e_valid = ev; v.e_ipc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req"},   {31'b0, bus.imem_req_out}, 32'd0);
    chk({tag, " addr"},  bus.imem_addr_out, 32'h0);
    chk({tag, " pc"},    pc, 32'h0);
    chk({tag, " valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, " instr"}, instr, NOP_INSTR);
    chk({tag, " ipc"},   instr_pc, 32'h0);
    chk({tag, " state"}, {30'b0, dut.state_q}, {30'b0, ST_BOOT});
  endtask

  initial begin
    // Each row: the outputs observed during a cycle, and the inputs
    // applied in that same cycle (taking effect at its closing edge).
    //            flush src br            trap      stl ack | req addr          vld ipc
    vecs[0]  = mk(1, 2'd0, 32'h0,        32'h0,    0, 1,   0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(1, 2'd3, 32'h0,        32'h0,    0, 1,   1, 32'h0,        0, 32'h0);
    vecs[2]  = mk(0, 2'd0, 32'h0,        32'h0,    0, 1,   1, 32'h4,        0, 32'h0);
    vecs[3]  = mk(0, 2'd0, 32'h0,        32'h0,    1, 1,   1, 32'h8,        1, 32'h4);
    vecs[4]  = mk(0, 2'd0, 32'h0,        32'h0,    1, 1,   0, 32'hC,        1, 32'h4);
    vecs[5]  = mk(0, 2'd0, 32'h0,        32'h0,    0, 1,   0, 32'hC,        1, 32'h4);
    vecs[6]  = mk(0, 2'd0, 32'h0,        32'h0,    0, 1,   1, 32'hC,        1, 32'h8);
    vecs[7]  = mk(1, 2'd1, 32'h203,      32'h0,    0, 0,   1, 32'h10,       1, 32'hC);
    vecs[8]  = mk(0, 2'd0, 32'h0,        32'h0,    0, 0,   1, 32'h10,       0, 32'h0);
    vecs[9]  = mk(0, 2'd0, 32'h0,        32'h0,    0, 1,   1, 32'h10,       0, 32'h0);
    vecs[10] = mk(0, 2'd0, 32'h0,        32'h0,    0, 1,   1, 32'h200,      0, 32'h0);
    vecs[11] = mk(1, 2'd2, 32'h0,        32'h80,   0, 1,   1, 32'h204,      1, 32'h200);
    vecs[12] = mk(0, 2'd0, 32'h0,        32'h0,    0, 1,   1, 32'h80,       0, 32'h0);
    vecs[13] = mk(1, 2'd1, 32'hFFFFFFFC, 32'h0,    0, 1,   1, 32'h84,       1, 32'h80);
    vecs[14] = mk(0, 2'd0, 32'h0,        32'h0,    0, 1,   1, 32'hFFFFFFFC, 0, 32'h0);
    vecs[15] = mk(0, 2'd0, 32'h0,        32'h0,    0, 0,   1, 32'h0,        1, 32'hFFFFFFFC);
    vecs[16] = mk(1, 2'd1, 32'h300,      32'h0,    0, 0,   1, 32'h0,        0, 32'h0);
    vecs[17] = mk(1, 2'd2, 32'h0,        32'h87,   0, 0,   1, 32'h0,        0, 32'h0);
    vecs[18] = mk(0, 2'd0, 32'h0,        32'h0,    0, 1,   1, 32'h0,        0, 32'h0);
    vecs[19] = mk(0, 2'd0, 32'h0,        32'h0,    0, 1,   1, 32'h84,       0, 32'h0);
    vecs[20] = mk(0, 2'd0, 32'h0,        32'h0,    1, 1,   1, 32'h88,       1, 32'h84);
    vecs[21] = mk(1, 2'd1, 32'h100,      32'h0,    1, 1,   0, 32'h8C,       1, 32'h84);
    vecs[22] = mk(1, 2'd1, 32'h400,      32'h0,    0, 0,   1, 32'h100,      0, 32'h0);

    rst_n = 1'b0; flush = 1'b0; pc_src = 2'd0; br_tgt = 32'h0;
    trap_tgt = 32'h0; stall = 1'b0; ack_en = 1'b0;

    #2;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      flush    = vecs[i].flush;
      pc_src   = vecs[i].src;
      br_tgt   = vecs[i].br;
      trap_tgt = vecs[i].trap;
      stall    = vecs[i].stall;
      ack_en   = vecs[i].ack;
      #1;
      chk($sformatf("v%0d req", i),   {31'b0, bus.imem_req_out}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d addr", i),  bus.imem_addr_out, vecs[i].e_addr);
      chk($sformatf("v%0d pc", i),    pc, vecs[i].e_addr);
      chk($sformatf("v%0d valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d instr", i), instr,
          vecs[i].e_valid ? (vecs[i].e_ipc + DATA_OFS) : NOP_INSTR);
      if (vecs[i].e_valid)
        chk($sformatf("v%0d ipc", i), instr_pc, vecs[i].e_ipc);
      $display("vec %0d: req=%0b addr=%08h valid=%0b ipc=%08h instr=%08h",
               i, bus.imem_req_out, bus.imem_addr_out, instr_valid, instr_pc, instr);
      @(posedge clk); #1;
    end

    // Now in DRAIN holding the 0x100 request; reset lands between edges
    // while an ack is pending.
    flush = 1'b0; ack_en = 1'b0;
    #1;
    chk("drain req",  {31'b0, bus.imem_req_out}, 32'd1);
    chk("drain addr", bus.imem_addr_out, 32'h100);
    chk("drain state", {30'b0, dut.state_q}, {30'b0, ST_DRAIN});
    $display("seq drain: req=%0b addr=%08h", bus.imem_req_out, bus.imem_addr_out);
    ack_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async rst");
    $display("seq async reset: req=%0b addr=%08h valid=%0b", bus.imem_req_out, bus.imem_addr_out, instr_valid);
    @(posedge clk); #1;
    chk_reset_outputs("rst held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("post rst");
    $display("seq post reset: req=%0b addr=%08h valid=%0b", bus.imem_req_out, bus.imem_addr_out, instr_valid);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
